multichannel_gain: RTL and testbench

//  Signed fixed-point gain stage for NUM_CH time-multiplexed control channels.

---
 rtl/multichannel_gain.sv | 142 ++++++++++++++
 tb/tb_multichannel_gain.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_gain.sv
// Multichannel signed gain stage.
// Time-multiplexed samples are scaled by a per-channel runtime gain, then
// rounded (half up) and saturated back to DATA_W through a 2-stage pipeline.
// Sticky statistics report dropped out-of-range channels and clamped outputs.
module multichannel_gain #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int GAIN_W = 16,
  parameter int FRAC   = 8,
  parameter logic signed [GAIN_W-1:0] DEFAULT_GAIN = GAIN_W'(1 << FRAC),
  parameter int CNT_W  = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     param_en,
  input  logic [CH_W-1:0]          param_addr,
  input  logic signed [GAIN_W-1:0] param_in,
  input  logic                     data_en,
  input  logic [CH_W-1:0]          data_ch,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     data_en_out,
  output logic [CH_W-1:0]          ch_out,
  output logic signed [DATA_W-1:0] out,
  output logic                     sat_out,
  output logic                     ch_err,
  output logic [CNT_W-1:0]         sat_cnt,
  input  logic                     clr_stats
);

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic signed [PROD_W:0] ROUND_HALF =
    (FRAC > 0) ? ((PROD_W + 1)'(1) << (FRAC - 1)) : '0;
  localparam logic signed [PROD_W:0] SAT_MAX =
    {{(PROD_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [PROD_W:0] SAT_MIN =
    {{(PROD_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

  // Add half an LSB of the output scale, then drop the fractional bits.
  // One guard bit keeps the rounding add from wrapping.
  function automatic logic signed [PROD_W:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] r;
    r = (PROD_W + 1)'(p) + ROUND_HALF;
    return r >>> FRAC;
  endfunction

  // Clamp to the DATA_W range; returns {clamped_flag, value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [PROD_W:0] s);
    if (s > SAT_MAX) begin
      return {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (s < SAT_MIN) begin
      return {1'b1, SAT_MIN[DATA_W-1:0]};
    end
    return {1'b0, s[DATA_W-1:0]};
  endfunction

  logic signed [GAIN_W-1:0] gain [NUM_CH];
  logic signed [GAIN_W-1:0] gain_sel;
  logic                     ch_ok;

  logic signed [PROD_W-1:0] prod_p1;
  logic [CH_W-1:0]          ch_p1;
  logic                     vld_p1;

  logic signed [DATA_W-1:0] res_p1;
  logic                     res_sat_p1;

  assign ch_ok = ({1'b0, data_ch} < CH_LIMIT);
  assign {res_sat_p1, res_p1} = saturate(round_shift(prod_p1));

  // Select the gain of the incoming channel (mux avoids out-of-range reads).
  always_comb begin
    gain_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (data_ch == CH_W'(i)) gain_sel = gain[i];
    end
  end

  // Gain register file; addresses beyond NUM_CH match no entry and are ignored.
  // The multiplier reads the pre-write value, so a same-cycle write affects the
  // next sample only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) gain[i] <= DEFAULT_GAIN;
    end else if (param_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (param_addr == CH_W'(i)) gain[i] <= param_in;
      end
    end
  end

  // ---- stage 1: full-precision product ----
  // Stage 1 control: valid and channel tag; invalid channels never enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      ch_p1  <= '0;
    end else begin
      vld_p1 <= data_en && ch_ok;
      if (data_en && ch_ok) ch_p1 <= data_ch;
    end
  end

  // Stage 1 data: product register, loaded only for accepted samples.
  always_ff @(posedge clk) begin
    if (data_en && ch_ok) prod_p1 <= PROD_W'(gain_sel) * PROD_W'(data_in);
  end

  // ---- stage 2: round, saturate, present ----
  // Output register; holds the last result while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_en_out <= 1'b0;
      ch_out      <= '0;
      out         <= '0;
      sat_out     <= 1'b0;
    end else begin
      data_en_out <= vld_p1;
      if (vld_p1) begin
        ch_out  <= ch_p1;
        out     <= res_p1;
        sat_out <= res_sat_p1;
      end
    end
  end

  // Sticky statistics; a clear takes priority over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_err  <= 1'b0;
      sat_cnt <= '0;
    end else if (clr_stats) begin
      ch_err  <= 1'b0;
      sat_cnt <= '0;
    end else begin
      if (data_en && !ch_ok) ch_err <= 1'b1;
      if (vld_p1 && res_sat_p1 && (sat_cnt != '1)) sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multichannel_gain.sv
// Testbench for multichannel_gain: directed cases plus randomized traffic,
// scored against a plain-arithmetic reference model; a second small build
// (3 channels, 4-bit counter) covers invalid channels and counter saturation.
module tb_multichannel_gain;

  localparam int NUM_CH = 4;
  localparam int FRAC   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        param_en = 1'b0;
  logic [1:0]  param_addr = '0;
  logic [15:0] param_in = '0;
  logic        data_en = 1'b0;
  logic [1:0]  data_ch = '0;
  logic [15:0] data_in = '0;
  logic        clr_stats = 1'b0;
  logic        data_en_out;
  logic [1:0]  ch_out;
  logic [15:0] out;
  logic        sat_out;
  logic        ch_err;
  logic [15:0] sat_cnt;

  logic        param_en_b = 1'b0;
  logic [1:0]  param_addr_b = '0;
  logic [15:0] param_in_b = '0;
  logic        data_en_b = 1'b0;
  logic [1:0]  data_ch_b = '0;
  logic [15:0] data_in_b = '0;
  logic        clr_stats_b = 1'b0;
  logic        data_en_out_b;
  logic [1:0]  ch_out_b;
  logic [15:0] out_b;
  logic        sat_out_b;
  logic        ch_err_b;
  logic [3:0]  sat_cnt_b;

  multichannel_gain #(.NUM_CH(4), .DATA_W(16), .GAIN_W(16), .FRAC(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .param_en(param_en), .param_addr(param_addr),
    .param_in(param_in), .data_en(data_en), .data_ch(data_ch), .data_in(data_in),
    .data_en_out(data_en_out), .ch_out(ch_out), .out(out), .sat_out(sat_out),
    .ch_err(ch_err), .sat_cnt(sat_cnt), .clr_stats(clr_stats)
  );

  multichannel_gain #(.NUM_CH(3), .DATA_W(16), .GAIN_W(16), .FRAC(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .param_en(param_en_b), .param_addr(param_addr_b),
    .param_in(param_in_b), .data_en(data_en_b), .data_ch(data_ch_b), .data_in(data_in_b),
    .data_en_out(data_en_out_b), .ch_out(ch_out_b), .out(out_b), .sat_out(sat_out_b),
    .ch_err(ch_err_b), .sat_cnt(sat_cnt_b), .clr_stats(clr_stats_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [15:0] val;
    logic [1:0]  ch;
    logic        sat;
    int          due;
  } exp_t;

  exp_t q[$];
  int   gm[NUM_CH];
  int   mcnt = 0;
  bit   merr = 0;
  bit   pend_sat = 0;
  int   edge_n = 0;

  // Scaled value: multiply, add half LSB, floor-divide by 2^FRAC, clamp.
  function automatic logic [16:0] model_gain(input int g, input int d);
    longint p, s;
    p = longint'(g) * longint'(d) + (longint'(1) << (FRAC - 1));
    s = p >>> FRAC;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, 16'(s)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) gm[i] = 1 << FRAC;
    mcnt = 0;
    merr = 0;
    pend_sat = 0;
    q.delete();
  endtask

  // One clock of the main DUT: apply inputs, update the model, wait for the
  // edge, then compare the statistics outputs.
  task automatic drive(input bit pen, input int paddr, input logic signed [15:0] pin,
                       input bit den, input int dch, input logic signed [15:0] din,
                       input bit clr);
    exp_t e;
    logic [16:0] r;
    if (clr) mcnt = 0;
    else if (pend_sat && mcnt != 16'hFFFF) mcnt = mcnt + 1;
    pend_sat = 0;
    if (clr) merr = 0;
    else if (den && dch >= NUM_CH) merr = 1;
    if (den && dch < NUM_CH) begin
      r = model_gain(gm[dch], int'(din));
      e.val = r[15:0];
      e.sat = r[16];
      e.ch  = 2'(dch);
      e.due = edge_n + 2;
      q.push_back(e);
      pend_sat = r[16];
    end
    if (pen && paddr < NUM_CH) gm[paddr] = int'(pin);
    param_en   = pen;
    param_addr = 2'(paddr);
    param_in   = pin;
    data_en    = den;
    data_ch    = 2'(dch);
    data_in    = din;
    clr_stats  = clr;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check("sat_cnt", sat_cnt, 64'(mcnt));
    check("ch_err", ch_err, 64'(merr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'sd0, 0, 0, 16'sd0, 0);
  endtask

  task automatic drive_b(input bit pen, input logic [15:0] pin, input bit den,
                         input int dch, input logic [15:0] din, input bit clr);
    param_en_b   = pen;
    param_addr_b = 2'd0;
    param_in_b   = pin;
    data_en_b    = den;
    data_ch_b    = 2'(dch);
    data_in_b    = din;
    clr_stats_b  = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard: every valid output must match the oldest expected entry at
  // the expected edge; nothing may appear unannounced or go missing.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (data_en_out) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("out", out, e.val);
          check("ch_out", ch_out, e.ch);
          check("sat_out", sat_out, e.sat);
          check("latency", 64'(edge_n), 64'(e.due));
        end
      end
      while (q.size() > 0 && q[0].due < edge_n) begin
        check("missing_valid", 64'd0, 64'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic signed [15:0] pin, din;
    model_reset();
    #1;
    check("rst_out", out, 64'd0);
    check("rst_ch_out", ch_out, 64'd0);
    check("rst_sat_out", sat_out, 64'd0);
    check("rst_vld", data_en_out, 64'd0);
    check("rst_ch_err", ch_err, 64'd0);
    check("rst_sat_cnt", sat_cnt, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Default unity gain, two-edge latency
    drive(0, 0, 16'sd0, 1, 2, 16'sd1000, 0);
    check("t1_vld_early", data_en_out, 64'd0);
    idle(1);
    check("t1_vld", data_en_out, 64'd1);
    check("t1_out", out, 64'd1000);
    check("t1_ch", ch_out, 64'd2);
    check("t1_sat", sat_out, 64'd0);
    idle(1);
    check("t1_idle_vld", data_en_out, 64'd0);
    check("t1_hold", out, 64'd1000);

    // Rounding half up
    drive(1, 1, 16'sh0180, 0, 0, 16'sd0, 0);
    drive(0, 0, 16'sd0, 1, 1, -16'sd3, 0);
    idle(1);
    check("t2_neg", out, 64'hFFFC);
    drive(1, 1, 16'sh0080, 0, 0, 16'sd0, 0);
    drive(0, 0, 16'sd0, 1, 1, 16'sd3, 0);
    idle(1);
    check("t2_half", out, 64'd2);

    // Saturation both ways
    drive(1, 0, 16'sh7FFF, 0, 0, 16'sd0, 0);
    drive(0, 0, 16'sd0, 1, 0, 16'sh7FFF, 0);
    idle(1);
    check("t3_max", out, 64'h7FFF);
    check("t3_max_sat", sat_out, 64'd1);
    drive(1, 0, 16'sh8000, 0, 0, 16'sd0, 0);
    drive(0, 0, 16'sd0, 1, 0, 16'sh7FFF, 0);
    idle(1);
    check("t3_min", out, 64'h8000);
    check("t3_min_sat", sat_out, 64'd1);
    check("t3_cnt", sat_cnt, 64'd2);

    // Clear wins over the increment landing on the same edge
    drive(0, 0, 16'sd0, 1, 0, 16'sh7FFF, 0);
    drive(0, 0, 16'sd0, 0, 0, 16'sd0, 1);
    check("clr_wins", sat_cnt, 64'd0);

    // Same-cycle write uses the old gain
    drive(1, 3, 16'sh0200, 1, 3, 16'sd10, 0);
    drive(0, 0, 16'sd0, 1, 3, 16'sd10, 0);
    check("t4_old", out, 64'd10);
    idle(1);
    check("t4_new", out, 64'd20);

    // Back-to-back stream over all channels, then reset mid-stream
    for (int c = 0; c < NUM_CH; c++) drive(1, c, 16'(32 * (c + 1)), 0, 0, 16'sd0, 0);
    for (int c = 0; c < NUM_CH; c++) drive(0, 0, 16'sd0, 1, c, 16'sd1234, 0);
    idle(2);
    drive(0, 0, 16'sd0, 1, 1, 16'sd500, 0);
    drive(0, 0, 16'sd0, 1, 2, 16'sd600, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", data_en_out, 64'd0);
    check("mid_rst_out", out, 64'd0);
    check("mid_rst_ch", ch_out, 64'd0);
    check("mid_rst_cnt", sat_cnt, 64'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(4);
    check("post_rst_vld", data_en_out, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) pin = 16'($urandom);
      else pin = 16'(int'($urandom_range(0, 1023)) - 512);
      din = 16'($urandom);
      drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), pin,
            $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), din,
            $urandom_range(0, 31) == 0);
    end
    idle(3);
    check("drained", 64'(q.size()), 64'd0);

    // Three-channel build: invalid channel, clear, counter saturation
    drive_b(0, 16'h0000, 1, 3, 16'd5, 0);
    drive_b(0, 16'h0000, 0, 0, 16'd0, 0);
    check("b_drop_vld1", data_en_out_b, 64'd0);
    drive_b(0, 16'h0000, 0, 0, 16'd0, 0);
    check("b_drop_vld2", data_en_out_b, 64'd0);
    check("b_ch_err", ch_err_b, 64'd1);
    drive_b(0, 16'h0000, 0, 0, 16'd0, 1);
    check("b_clr_err", ch_err_b, 64'd0);
    check("b_clr_cnt", sat_cnt_b, 64'd0);
    drive_b(1, 16'h7FFF, 0, 0, 16'd0, 0);
    for (int n = 0; n < 20; n++) drive_b(0, 16'h0000, 1, 0, 16'h7FFF, 0);
    drive_b(0, 16'h0000, 0, 0, 16'd0, 0);
    drive_b(0, 16'h0000, 0, 0, 16'd0, 0);
    check("b_cnt_stick", sat_cnt_b, 64'hF);
    check("b_out", out_b, 64'h7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
